// File: rtl/forney_pkg.sv
// Shared types and GF(2^10) arithmetic for the Forney S2 stage.
// Field: polynomial basis, p(x) = x^10 + x^3 + 1.
package forney_pkg;

  localparam int unsigned GF_W     = 10;
  localparam int unsigned POS_W    = 10;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned GF_SIZE  = 1 << GF_W;
  localparam logic [GF_W-1:0] GF_POLY = 10'h009;

  typedef logic [GF_W-1:0] gf_t;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    gf_t              mag;
    logic             fail;
  } s2_item_t;

  // Shift-and-add multiply with on-the-fly reduction by x^10 = x^3 + 1.
  function automatic gf_t gf_mul(gf_t a, gf_t b);
    gf_t r;
    gf_t x;
    r = '0;
    x = a;
    for (int unsigned i = 0; i < GF_W; i++) begin
      if (b[i]) r = r ^ x;
      x = x[GF_W-1] ? ((x << 1) ^ GF_POLY) : (x << 1);
    end
    return r;
  endfunction

  // a^(2^10 - 2) is the inverse for a != 0 and naturally yields 0 for a == 0.
  function automatic gf_t gf_inv(gf_t a);
    gf_t r;
    gf_t base;
    r    = gf_t'(1);
    base = a;
    for (int unsigned i = 0; i < GF_W; i++) begin
      if (i != 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf1024_inv.sv
// Combinational 1024-entry GF(2^10) inverse lookup table; inv(0) = 0.
module gf1024_inv
  import forney_pkg::*;
(
  input  gf_t a_i,
  output gf_t inv_c
);

  gf_t lut [GF_SIZE];

  // Each entry folds to a constant at elaboration.
  for (genvar g = 0; g < GF_SIZE; g++) begin : g_lut
    assign lut[g] = gf_inv(GF_W'(g));
  end

  assign inv_c = lut[a_i];

endmodule

// File: rtl/gf1024_mul.sv
// Combinational GF(2^10) multiplier wrapper.
module gf1024_mul
  import forney_pkg::*;
(
  input  gf_t a_i,
  input  gf_t b_i,
  output gf_t p_c
);

  assign p_c = gf_mul(a_i, b_i);

endmodule

// File: rtl/forney_pipe_s2.sv
// Forney stage S2: e = phase * num * den^-1, two elastic register stages.
// Optional accepted-error counter enabled by FORNEY_S2_ERR_CNT_EN.
module forney_pipe_s2
  import forney_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             s1_vld_i,
  output logic             s2_rdy_o,
  input  logic [POS_W-1:0] pos_i,
  input  gf_t              num_i,
  input  gf_t              den_i,
  input  gf_t              phase_i,
  output logic             err_vld_o,
  input  logic             err_rdy_i,
  output logic [POS_W-1:0] err_pos_o,
  output gf_t              err_mag_o,
  output logic             err_fail_o
`ifdef FORNEY_S2_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt_o
`endif
);

  logic             v_a_q, v_a_d;
  logic [POS_W-1:0] pos_a_q, pos_a_d;
  gf_t              prod_a_q, prod_a_d;
  gf_t              inv_a_q, inv_a_d;
  logic             fail_a_q, fail_a_d;
  logic             v_b_q, v_b_d;
  s2_item_t         item_b_q, item_b_d;

  gf_t  prod_in;
  gf_t  inv_in;
  gf_t  mag_a;
  logic fire_in;
  logic adv_b;

  gf1024_mul u_mul_in  (.a_i(num_i),    .b_i(phase_i), .p_c(prod_in));
  gf1024_inv u_inv     (.a_i(den_i),    .inv_c(inv_in));
  gf1024_mul u_mul_out (.a_i(prod_a_q), .b_i(inv_a_q), .p_c(mag_a));

  // Handshake: S1 holds nothing, so ready must reflect real capacity.
  assign adv_b    = v_a_q & (~v_b_q | err_rdy_i);
  assign s2_rdy_o = ~flush_i & (~v_a_q | adv_b);
  assign fire_in  = s1_vld_i & s2_rdy_o;

  always_comb begin
    v_a_d    = v_a_q;
    pos_a_d  = pos_a_q;
    prod_a_d = prod_a_q;
    inv_a_d  = inv_a_q;
    fail_a_d = fail_a_q;
    v_b_d    = v_b_q;
    item_b_d = item_b_q;

    if (fire_in) begin
      v_a_d    = 1'b1;
      pos_a_d  = pos_i;
      prod_a_d = prod_in;
      inv_a_d  = inv_in;
      fail_a_d = (den_i == '0);
    end else if (adv_b) begin
      v_a_d = 1'b0;
    end

    if (adv_b) begin
      v_b_d         = 1'b1;
      item_b_d.pos  = pos_a_q;
      item_b_d.mag  = fail_a_q ? '0 : mag_a;
      item_b_d.fail = fail_a_q;
    end else if (err_rdy_i) begin
      v_b_d = 1'b0;
    end

    if (flush_i) begin
      v_a_d = 1'b0;
      v_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_a_q    <= 1'b0;
      pos_a_q  <= '0;
      prod_a_q <= '0;
      inv_a_q  <= '0;
      fail_a_q <= 1'b0;
      v_b_q    <= 1'b0;
      item_b_q <= '0;
    end else begin
      v_a_q    <= v_a_d;
      pos_a_q  <= pos_a_d;
      prod_a_q <= prod_a_d;
      inv_a_q  <= inv_a_d;
      fail_a_q <= fail_a_d;
      v_b_q    <= v_b_d;
      item_b_q <= item_b_d;
    end
  end

  assign err_vld_o  = v_b_q;
  assign err_pos_o  = item_b_q.pos;
  assign err_mag_o  = item_b_q.mag;
  assign err_fail_o = item_b_q.fail;

`ifdef FORNEY_S2_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts delivered correctable, nonzero magnitudes; flush takes priority.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (v_b_q && err_rdy_i && (item_b_q.mag != '0) && !item_b_q.fail
                 && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign err_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_forney_pipe_s2.sv
// Self-checking bench for forney_pipe_s2: directed vectors, backpressure,
// flush/reset sequences and a randomized soak against a queue-based model.
module tb_forney_pipe_s2;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic       s1_vld_i = 1'b0;
  logic       s2_rdy_o;
  logic [9:0] pos_i = '0;
  logic [9:0] num_i = '0;
  logic [9:0] den_i = '0;
  logic [9:0] phase_i = '0;
  logic       err_vld_o;
  logic       err_rdy_i = 1'b0;
  logic [9:0] err_pos_o;
  logic [9:0] err_mag_o;
  logic       err_fail_o;
`ifdef FORNEY_S2_ERR_CNT_EN
  logic [3:0] err_cnt_o;
`endif

  forney_pipe_s2 dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .s1_vld_i   (s1_vld_i),
    .s2_rdy_o   (s2_rdy_o),
    .pos_i      (pos_i),
    .num_i      (num_i),
    .den_i      (den_i),
    .phase_i    (phase_i),
    .err_vld_o  (err_vld_o),
    .err_rdy_i  (err_rdy_i),
    .err_pos_o  (err_pos_o),
    .err_mag_o  (err_mag_o),
    .err_fail_o (err_fail_o)
`ifdef FORNEY_S2_ERR_CNT_EN
    ,
    .err_cnt_o  (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned pos;
    int unsigned mag;
    bit          fail;
    int          cyc;
  } exp_t;

  typedef struct {
    int unsigned pos;
    int unsigned num;
    int unsigned den;
    int unsigned phase;
    int unsigned mag;
    bit          fail;
  } vec_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          emitted = 0;
  bit          accepted;
  bit          hold_pending = 0;
  int unsigned held_pos, held_mag, held_fail;
  int unsigned last_pos, last_mag, last_fail;
  int unsigned cnt_m = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Carry-less product reduced by x^10 + x^3 + 1 (long division).
  function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b);
    int unsigned p;
    p = 0;
    for (int i = 0; i < 10; i++)
      if (b[i]) p = p ^ (a << i);
    for (int i = 18; i >= 10; i--)
      if (p[i]) p = p ^ (32'h409 << (i - 10));
    return p & 32'h3ff;
  endfunction

  function automatic int unsigned ref_inv(input int unsigned a);
    for (int unsigned x = 1; x < 1024; x++)
      if (ref_mul(a, x) == 1) return x;
    return 0;
  endfunction

  // One clock: check outputs against the model at the falling edge, then update it.
  task automatic tick();
    int   n;
    bit   exp_rdy;
    bit   exp_vld;
    exp_t e;
    @(negedge clk_i);
    n       = q.size();
    exp_rdy = !flush_i && (n < 2 || err_rdy_i);
    exp_vld = 0;
    if (n > 0) exp_vld = (cyc - q[0].cyc) >= 2;
    chk("s2_rdy", 32'(s2_rdy_o), 32'(exp_rdy));
    chk("err_vld", 32'(err_vld_o), 32'(exp_vld));
    if (hold_pending) begin
      chk("hold_pos", 32'(err_pos_o), held_pos);
      chk("hold_mag", 32'(err_mag_o), held_mag);
      chk("hold_fail", 32'(err_fail_o), held_fail);
    end
`ifdef FORNEY_S2_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt_o), cnt_m);
`endif
    accepted = 0;
    if (err_vld_o && err_rdy_i && n > 0) begin
      e = q.pop_front();
      chk("out_pos", 32'(err_pos_o), e.pos);
      chk("out_mag", 32'(err_mag_o), e.mag);
      chk("out_fail", 32'(err_fail_o), 32'(e.fail));
      last_pos  = 32'(err_pos_o);
      last_mag  = 32'(err_mag_o);
      last_fail = 32'(err_fail_o);
      emitted++;
      if (e.mag != 0 && !e.fail && cnt_m < 15) cnt_m++;
    end
    hold_pending = err_vld_o && !err_rdy_i && !flush_i;
    held_pos  = 32'(err_pos_o);
    held_mag  = 32'(err_mag_o);
    held_fail = 32'(err_fail_o);
    if (s1_vld_i && s2_rdy_o) begin
      e.pos  = 32'(pos_i);
      e.fail = (den_i == 0);
      e.mag  = e.fail ? 0 : ref_mul(ref_mul(32'(phase_i), 32'(num_i)), ref_inv(32'(den_i)));
      e.cyc  = cyc;
      q.push_back(e);
      accepted = 1;
    end
    if (flush_i) begin
      q.delete();
      cnt_m = 0;
    end
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    s1_vld_i = 0;
    flush_i  = 0;
    rst_ni   = 0;
    #1;
    chk("rst_vld", 32'(err_vld_o), 0);
    chk("rst_pos", 32'(err_pos_o), 0);
    chk("rst_mag", 32'(err_mag_o), 0);
    chk("rst_fail", 32'(err_fail_o), 0);
`ifdef FORNEY_S2_ERR_CNT_EN
    chk("rst_cnt", 32'(err_cnt_o), 0);
`endif
    q.delete();
    hold_pending = 0;
    cnt_m = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i);
    #1;
    chk("rst_rdy", 32'(s2_rdy_o), 1);
  endtask

  task automatic drive(input int unsigned p, input int unsigned nm, input int unsigned dn,
                       input int unsigned ph);
    s1_vld_i = 1;
    pos_i    = 10'(p);
    num_i    = 10'(nm);
    den_i    = 10'(dn);
    phase_i  = 10'(ph);
  endtask

  vec_t tbl [7];
  int   idx;
  int   e0;
  int   acc;

  initial begin
    tbl[0] = '{pos: 5,  num: 'h001, den: 'h001, phase: 'h001, mag: 'h001, fail: 0};
    tbl[1] = '{pos: 6,  num: 'h002, den: 'h002, phase: 'h004, mag: 'h004, fail: 0};
    tbl[2] = '{pos: 7,  num: 'h200, den: 'h001, phase: 'h002, mag: 'h009, fail: 0};
    tbl[3] = '{pos: 8,  num: 'h123, den: 'h000, phase: 'h055, mag: 'h000, fail: 1};
    tbl[4] = '{pos: 9,  num: 'h000, den: 'h007, phase: 'h003, mag: 'h000, fail: 0};
    tbl[5] = '{pos: 10, num: 'h001, den: 'h002, phase: 'h001, mag: 'h204, fail: 0};
    tbl[6] = '{pos: 11, num: 'h200, den: 'h200, phase: 'h3ff, mag: 'h3ff, fail: 0};

    do_reset();

    // Directed vectors, one at a time with the output always ready.
    err_rdy_i = 1;
    for (int i = 0; i < 7; i++) begin
      e0 = emitted;
      drive(tbl[i].pos, tbl[i].num, tbl[i].den, tbl[i].phase);
      tick();
      chk("tbl_accept", 32'(accepted), 1);
      s1_vld_i = 0;
      tick();
      tick();
      chk("tbl_emit", 32'(emitted - e0), 1);
      chk("tbl_pos", last_pos, tbl[i].pos);
      chk("tbl_mag", last_mag, tbl[i].mag);
      chk("tbl_fail", last_fail, 32'(tbl[i].fail));
    end

    // Backpressure: three items offered, S1 keeps presenting until accepted.
    err_rdy_i = 0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 3) drive(20 + idx, 'h10 + idx, 'h3 + idx, 'h1);
      else s1_vld_i = 0;
      tick();
      if (accepted) idx++;
    end
    chk("bp_accepts", 32'(idx), 2);
    err_rdy_i = 1;
    e0 = emitted;
    for (int c = 0; c < 8; c++) begin
      if (idx < 3) drive(20 + idx, 'h10 + idx, 'h3 + idx, 'h1);
      else s1_vld_i = 0;
      tick();
      if (accepted) idx++;
    end
    chk("bp_all_in", 32'(idx), 3);
    chk("bp_all_out", 32'(emitted - e0), 3);

    // Flush with both stages full; a same-cycle offer must be dropped.
    err_rdy_i = 1;
    drive(30, 'h155, 'h0aa, 'h0f0);
    tick();
    drive(31, 'h001, 'h001, 'h001);
    tick();
    s1_vld_i = 0;
    err_rdy_i = 0;
    tick();
    drive(32, 'h011, 'h022, 'h033);
    tick();
    drive(33, 'h044, 'h055, 'h066);
    tick();
    chk("pre_flush_q", 32'(q.size()), 2);
    flush_i = 1;
    drive(34, 'h077, 'h088, 'h099);
    tick();
    flush_i = 0;
    s1_vld_i = 0;
    tick();
    chk("post_flush_vld", 32'(err_vld_o), 0);
    tick();

    // Reset in the middle of a stream.
    err_rdy_i = 1;
    for (int c = 0; c < 3; c++) begin
      drive(40 + c, $urandom_range(1023), $urandom_range(1023), $urandom_range(1023));
      tick();
    end
    do_reset();

    // Randomized soak: 1000 accepted items under random backpressure and rare flushes.
    acc = 0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      s1_vld_i  = ($urandom_range(3) != 0);
      pos_i     = 10'($urandom);
      num_i     = 10'($urandom);
      den_i     = ($urandom_range(15) == 0) ? 10'h000 : 10'($urandom);
      phase_i   = 10'($urandom);
      err_rdy_i = ($urandom_range(9) < 7);
      flush_i   = ($urandom_range(299) == 0);
      tick();
      if (accepted) acc++;
    end
    chk("soak_items", 32'(acc), 1000);
    s1_vld_i  = 0;
    flush_i   = 0;
    err_rdy_i = 1;
    for (int c = 0; c < 10 && q.size() > 0; c++) tick();
    chk("drain_empty", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
